// File: rtl/adc_reader_if.sv
// Loop-side handshake of the ADC reader: arm/conv request in, signed sample and
// level "finished" flag out.
interface adc_reader_if #(
  parameter int ADC_WID = 18
);
  logic                      arm;
  logic                      conv;
  logic signed [ADC_WID-1:0] measured_value;
  logic                      finished;

  // master = control loop, slave = adc_reader
  modport master (output arm, conv, input measured_value, finished);
  modport slave  (input arm, conv, output measured_value, finished);
endinterface

// File: rtl/adc_reader.sv
// One CNV pulse plus an MSB-first SCK/SDO readback from an 18-bit SAR ADC per
// arm&conv request; the sample is held with finished=1 until arm drops.
module adc_reader #(
  parameter int ADC_WID         = 18,
  parameter int CONV_CYCLES     = 60,
  parameter int SCK_HALF_CYCLES = 2,
  parameter int TIMER_WID       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  adc_reader_if.slave   loop,
  output logic          cnv_pin,
  output logic          sck,
  input  logic          sdo,
  output logic [2:0]    state
);

  // Handshake: a read starts on an edge that samples arm=1 and conv=1 in IDLE.
  // finished is a level: it rises with the new measured_value and stays high
  // until an edge samples arm=0; arm=0 earlier abandons the read silently.

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] CONVERT    = 3'd1;
  localparam logic [2:0] SHIFT_LOW  = 3'd2;
  localparam logic [2:0] SHIFT_HIGH = 3'd3;
  localparam logic [2:0] DONE       = 3'd4;

  localparam int CNT_WID = $clog2(ADC_WID + 1);

  localparam logic [TIMER_WID-1:0] CONV_LAST = TIMER_WID'(CONV_CYCLES);
  localparam logic [TIMER_WID-1:0] HALF_LAST = TIMER_WID'(SCK_HALF_CYCLES);
  localparam logic [TIMER_WID-1:0] TIMER_ONE = TIMER_WID'(1);
  localparam logic [CNT_WID-1:0]   LAST_BIT  = CNT_WID'(ADC_WID - 1);

  logic [TIMER_WID-1:0] timer;
  logic [CNT_WID-1:0]   bit_cnt;
  logic [ADC_WID-1:0]   shift;

  // timer counts the cycles already spent in the current phase, starting at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      timer               <= '0;
      bit_cnt             <= '0;
      shift               <= '0;
      cnv_pin             <= 1'b0;
      sck                 <= 1'b0;
      loop.measured_value <= '0;
      loop.finished       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (loop.arm && loop.conv) begin
            cnv_pin <= 1'b1;
            timer   <= TIMER_ONE;
            state   <= CONVERT;
          end
        end

        CONVERT: begin
          if (!loop.arm) begin
            cnv_pin <= 1'b0;
            timer   <= '0;
            state   <= IDLE;
          end else if (timer == CONV_LAST) begin
            cnv_pin <= 1'b0;
            timer   <= TIMER_ONE;
            bit_cnt <= '0;
            state   <= SHIFT_LOW;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        SHIFT_LOW: begin
          if (!loop.arm) begin
            sck   <= 1'b0;
            timer <= '0;
            state <= IDLE;
          end else if (timer == HALF_LAST) begin
            // sdo has been stable since the previous SCK fall
            sck   <= 1'b1;
            shift <= {shift[ADC_WID-2:0], sdo};
            timer <= TIMER_ONE;
            state <= SHIFT_HIGH;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        SHIFT_HIGH: begin
          if (timer == HALF_LAST && bit_cnt == LAST_BIT) begin
            // completion wins over a simultaneous arm drop
            sck                 <= 1'b0;
            bit_cnt             <= bit_cnt + 1'b1;
            timer               <= '0;
            loop.measured_value <= shift;
            loop.finished       <= 1'b1;
            state               <= DONE;
          end else if (!loop.arm) begin
            sck   <= 1'b0;
            timer <= '0;
            state <= IDLE;
          end else if (timer == HALF_LAST) begin
            sck     <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            timer   <= TIMER_ONE;
            state   <= SHIFT_LOW;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DONE: begin
          if (!loop.arm) begin
            loop.finished <= 1'b0;
            state         <= IDLE;
          end
        end

        default: begin
          cnv_pin       <= 1'b0;
          sck           <= 1'b0;
          loop.finished <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
